// File: rtl/tahmin_tablosu_denetleyici_if.sv
// Interface between the gshare PHT controller and its neighbours.
// Carries the fetch lookup handshake, the execute update handshake, the
// single-port table RAM port and the status outputs (clear done, history).
// slave : controller view (drives handshake readies, prediction, RAM port).
// master: environment view (fetch/execute stages and the table RAM).
interface tahmin_tablosu_denetleyici_if #(
    parameter int unsigned GECMIS_BIT = 10
) ();
    logic                  getir_gecerli;
    logic [31:0]           getir_ps;
    logic                  getir_hazir;
    logic                  tahmin_gecerli;
    logic                  tahmin_dallan;
    logic                  yurut_gecerli;
    logic [31:0]           yurut_ps;
    logic                  yurut_dallan;
    logic                  yurut_hazir;
    logic                  tablo_en;
    logic                  tablo_yaz;
    logic [GECMIS_BIT-1:0] tablo_adres;
    logic [1:0]            tablo_yaz_veri;
    logic [1:0]            tablo_oku_veri;
    logic                  temizleme_bitti;
    logic [GECMIS_BIT-1:0] gecmis;

    modport slave (
        input  getir_gecerli, getir_ps, yurut_gecerli, yurut_ps, yurut_dallan, tablo_oku_veri,
        output getir_hazir, tahmin_gecerli, tahmin_dallan, yurut_hazir, tablo_en, tablo_yaz,
               tablo_adres, tablo_yaz_veri, temizleme_bitti, gecmis
    );

    modport master (
        output getir_gecerli, getir_ps, yurut_gecerli, yurut_ps, yurut_dallan, tablo_oku_veri,
        input  getir_hazir, tahmin_gecerli, tahmin_dallan, yurut_hazir, tablo_en, tablo_yaz,
               tablo_adres, tablo_yaz_veri, temizleme_bitti, gecmis
    );
endinterface

// File: rtl/tahmin_tablosu_denetleyici.sv
// gshare pattern-history table controller.
// Owns the global history, clears the external 2-bit table after reset,
// serves fetch lookups and applies execute updates (read-modify-write of a
// saturating counter) through a small FIFO, sharing one RAM port.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   bag_io - fetch/execute handshakes, table RAM port, status (see interface)
module tahmin_tablosu_denetleyici #(
    parameter int unsigned GECMIS_BIT    = 10,
    parameter int unsigned FIFO_DERINLIK = 4,
    parameter logic [1:0]  BASLANGIC     = 2'b10
) (
    input logic                         clk,
    input logic                         rst,
    tahmin_tablosu_denetleyici_if.slave bag_io
);
    localparam int unsigned PW = $clog2(FIFO_DERINLIK);

    typedef enum logic {StTemizle, StCalis} durum_e;
    typedef enum logic [1:0] {MotorBos, MotorOku, MotorYaz} motor_e;

    durum_e                durum_q, durum_d;
    motor_e                motor_q, motor_d;
    logic [GECMIS_BIT-1:0] supur_q, supur_d;
    logic                  bitti_q, bitti_d;
    logic [GECMIS_BIT-1:0] gecmis_q, gecmis_d;
    logic [PW-1:0]         yaz_ptr_q, yaz_ptr_d;
    logic [PW-1:0]         oku_ptr_q, oku_ptr_d;
    logic [PW:0]           say_q, say_d;
    logic [1:0]            sayac_q, sayac_d;
    logic                  tahmin_gecerli_q, tahmin_gecerli_d;

    logic [GECMIS_BIT-1:0] fifo_idx_q [FIFO_DERINLIK];
    logic                  fifo_dal_q [FIFO_DERINLIK];

    logic                  calis, dolu, bos;
    logic                  getir_kabul, ekle, cikar, motor_oku;
    logic [GECMIS_BIT-1:0] getir_idx, yurut_idx, bas_idx;
    logic                  bas_dal;
    logic [1:0]            yeni_sayac;
    logic                  unused_ps;

    assign unused_ps = ^{bag_io.getir_ps[31:GECMIS_BIT+2], bag_io.getir_ps[1:0],
                         bag_io.yurut_ps[31:GECMIS_BIT+2], bag_io.yurut_ps[1:0],
                         bag_io.tablo_oku_veri[0]};

    assign calis     = (durum_q == StCalis);
    assign dolu      = (say_q == (PW+1)'(FIFO_DERINLIK));
    assign bos       = (say_q == '0);
    assign getir_idx = bag_io.getir_ps[GECMIS_BIT+1:2] ^ gecmis_q;
    assign yurut_idx = bag_io.yurut_ps[GECMIS_BIT+1:2] ^ gecmis_q;
    assign bas_idx   = fifo_idx_q[oku_ptr_q];
    assign bas_dal   = fifo_dal_q[oku_ptr_q];

    // A full FIFO stalls fetch so the engine is guaranteed a free read slot.
    assign bag_io.getir_hazir = calis && (motor_q != MotorYaz) && !dolu;
    assign bag_io.yurut_hazir = calis && !dolu;

    assign getir_kabul = bag_io.getir_gecerli && bag_io.getir_hazir;
    assign ekle        = bag_io.yurut_gecerli && bag_io.yurut_hazir;
    assign cikar       = calis && (motor_q == MotorYaz);
    // Engine read only goes out when fetch leaves the port free.
    assign motor_oku   = calis && (motor_q == MotorBos) && !getir_kabul && !bos;

    always_comb begin
        yeni_sayac = sayac_q;
        if (bas_dal) begin
            if (sayac_q != 2'b11) yeni_sayac = sayac_q + 2'b01;
        end else begin
            if (sayac_q != 2'b00) yeni_sayac = sayac_q - 2'b01;
        end
    end

    // RAM port arbitration: sweep, engine write, fetch read, engine read.
    always_comb begin
        bag_io.tablo_en       = 1'b0;
        bag_io.tablo_yaz      = 1'b0;
        bag_io.tablo_adres    = '0;
        bag_io.tablo_yaz_veri = 2'b00;
        if (!calis) begin
            bag_io.tablo_en       = 1'b1;
            bag_io.tablo_yaz      = 1'b1;
            bag_io.tablo_adres    = supur_q;
            bag_io.tablo_yaz_veri = BASLANGIC;
        end else if (motor_q == MotorYaz) begin
            bag_io.tablo_en       = 1'b1;
            bag_io.tablo_yaz      = 1'b1;
            bag_io.tablo_adres    = bas_idx;
            bag_io.tablo_yaz_veri = yeni_sayac;
        end else if (getir_kabul) begin
            bag_io.tablo_en    = 1'b1;
            bag_io.tablo_adres = getir_idx;
        end else if (motor_oku) begin
            bag_io.tablo_en    = 1'b1;
            bag_io.tablo_adres = bas_idx;
        end
    end

    always_comb begin
        durum_d          = durum_q;
        motor_d          = motor_q;
        supur_d          = supur_q;
        bitti_d          = bitti_q;
        gecmis_d         = gecmis_q;
        yaz_ptr_d        = yaz_ptr_q;
        oku_ptr_d        = oku_ptr_q;
        say_d            = say_q;
        sayac_d          = sayac_q;
        tahmin_gecerli_d = getir_kabul;

        if (durum_q == StTemizle) begin
            supur_d = supur_q + 1'b1;
            if (supur_q == '1) begin
                durum_d = StCalis;
                bitti_d = 1'b1;
            end
        end

        unique case (motor_q)
            MotorBos: if (motor_oku) motor_d = MotorOku;
            MotorOku: begin
                // Registered RAM data for the engine read arrives here.
                sayac_d = bag_io.tablo_oku_veri;
                motor_d = MotorYaz;
            end
            MotorYaz: motor_d = MotorBos;
            default:  motor_d = MotorBos;
        endcase

        if (ekle) begin
            gecmis_d  = {gecmis_q[GECMIS_BIT-2:0], bag_io.yurut_dallan};
            yaz_ptr_d = yaz_ptr_q + PW'(1);
        end
        if (cikar) oku_ptr_d = oku_ptr_q + PW'(1);
        if (ekle && !cikar) say_d = say_q + 1'b1;
        else if (!ekle && cikar) say_d = say_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum_q          <= StTemizle;
            motor_q          <= MotorBos;
            supur_q          <= '0;
            bitti_q          <= 1'b0;
            gecmis_q         <= '0;
            yaz_ptr_q        <= '0;
            oku_ptr_q        <= '0;
            say_q            <= '0;
            sayac_q          <= 2'b00;
            tahmin_gecerli_q <= 1'b0;
        end else begin
            durum_q          <= durum_d;
            motor_q          <= motor_d;
            supur_q          <= supur_d;
            bitti_q          <= bitti_d;
            gecmis_q         <= gecmis_d;
            yaz_ptr_q        <= yaz_ptr_d;
            oku_ptr_q        <= oku_ptr_d;
            say_q            <= say_d;
            sayac_q          <= sayac_d;
            tahmin_gecerli_q <= tahmin_gecerli_d;
        end
    end

    // Storage is qualified by the pointers/count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (ekle) begin
            fifo_idx_q[yaz_ptr_q] <= yurut_idx;
            fifo_dal_q[yaz_ptr_q] <= bag_io.yurut_dallan;
        end
    end

    assign bag_io.tahmin_gecerli  = tahmin_gecerli_q;
    assign bag_io.tahmin_dallan   = tahmin_gecerli_q & bag_io.tablo_oku_veri[1];
    assign bag_io.temizleme_bitti = bitti_q;
    assign bag_io.gecmis          = gecmis_q;
endmodule

// File: tb/tb_tahmin_tablosu_denetleyici.sv
module tb_tahmin_tablosu_denetleyici;
    localparam int unsigned G = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tahmin_tablosu_denetleyici_if #(.GECMIS_BIT(G)) bag ();

    tahmin_tablosu_denetleyici #(
        .GECMIS_BIT   (G),
        .FIFO_DERINLIK(4),
        .BASLANGIC    (2'b10)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bag_io(bag)
    );

    // Table RAM model: single port, registered read.
    logic [1:0] ram [1<<G];
    logic [1:0] ram_oku_q;
    always @(posedge clk) begin
        if (bag.tablo_en === 1'b1) begin
            if (bag.tablo_yaz) ram[bag.tablo_adres] <= bag.tablo_yaz_veri;
            else ram_oku_q <= ram[bag.tablo_adres];
        end
    end
    assign bag.tablo_oku_veri = ram_oku_q;

    typedef struct {
        logic kontrol;
        logic beklenen;
    } sb_t;

    typedef struct {
        logic       dallan;
        logic [1:0] sayac;
        logic       tahmin;
    } vektor_t;

    sb_t          sb_q [$];
    logic         bekleyen = 1'b0;
    logic [G-1:0] ref_g = '0;
    int           checks = 0;
    int           errors = 0;
    vektor_t      vek [7];

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", ad, gercek, beklenen);
        end
    endtask

    // One clock: drive after the edge, sample at the falling edge.
    task automatic cyc(input logic r, input logic gv, input logic [31:0] gps, input logic yv,
                       input logic [31:0] yps, input logic yd, input logic skk,
                       input logic sbe);
        sb_t e;
        @(posedge clk);
        #1;
        rst               = r;
        bag.getir_gecerli = gv;
        bag.getir_ps      = gps;
        bag.yurut_gecerli = yv;
        bag.yurut_ps      = yps;
        bag.yurut_dallan  = yd;
        @(negedge clk);
        if (bekleyen) begin
            e = sb_q.pop_front();
            kontrol("tahmin_gecerli", 32'(bag.tahmin_gecerli), 32'd1);
            if (e.kontrol) kontrol("tahmin_dallan", 32'(bag.tahmin_dallan), 32'(e.beklenen));
        end else begin
            kontrol("tahmin_bos", 32'({bag.tahmin_gecerli, bag.tahmin_dallan}), 32'd0);
        end
        bekleyen = gv && bag.getir_hazir && !r;
        if (bekleyen) sb_q.push_back('{skk, sbe});
        if (yv && bag.yurut_hazir && !r) ref_g = {ref_g[G-2:0], yd};
        if (r) begin
            ref_g = '0;
            sb_q.delete();
        end
    endtask

    task automatic bekle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] ps_for(input logic [G-1:0] idx, input logic [G-1:0] g);
        return 32'({idx ^ g, 2'b00});
    endfunction

    // Clear sweep after a reset edge has just been taken.
    task automatic supurme();
        int bad;
        int ram_bad;
        int port_kullanim;
        bad = 0;
        ram_bad = 0;
        port_kullanim = 0;
        for (int i = 0; i < (1 << G); i++) begin
            bekle(1);
            if (i == 0) begin
                kontrol("reset_gecmis", 32'(bag.gecmis), 32'd0);
                kontrol("reset_hazir_bitti",
                        32'({bag.getir_hazir, bag.yurut_hazir, bag.temizleme_bitti}), 32'd0);
            end
            if (!(bag.tablo_en === 1'b1 && bag.tablo_yaz === 1'b1 &&
                  bag.tablo_adres === i[G-1:0] && bag.tablo_yaz_veri === 2'b10 &&
                  bag.getir_hazir === 1'b0 && bag.yurut_hazir === 1'b0 &&
                  bag.temizleme_bitti === 1'b0)) bad++;
        end
        kontrol("sweep_bad_cycles", 32'(bad), 32'd0);
        bekle(1);
        kontrol("temizleme_bitti", 32'(bag.temizleme_bitti), 32'd1);
        kontrol("getir_hazir_after_sweep", 32'(bag.getir_hazir), 32'd1);
        for (int i = 0; i < (1 << G); i++) if (ram[i] !== 2'b10) ram_bad++;
        kontrol("ram_cleared", 32'(ram_bad), 32'd0);
        for (int i = 0; i < 8; i++) begin
            bekle(1);
            if (bag.tablo_en !== 1'b0) port_kullanim++;
        end
        kontrol("idle_no_access", 32'(port_kullanim), 32'd0);
    endtask

    initial begin
        logic [G-1:0] hedef;
        logic [G-1:0] adr_a;
        logic [G-1:0] adr_b;
        logic [G-1:0] bp_adr [4];
        logic         bp_dal [4];

        bag.getir_gecerli = 1'b0;
        bag.getir_ps      = 32'd0;
        bag.yurut_gecerli = 1'b0;
        bag.yurut_ps      = 32'd0;
        bag.yurut_dallan  = 1'b0;

        vek[0] = '{1'b1, 2'b11, 1'b1};
        vek[1] = '{1'b1, 2'b11, 1'b1};
        vek[2] = '{1'b1, 2'b11, 1'b1};
        vek[3] = '{1'b0, 2'b10, 1'b1};
        vek[4] = '{1'b0, 2'b01, 1'b0};
        vek[5] = '{1'b0, 2'b00, 1'b0};
        vek[6] = '{1'b0, 2'b00, 1'b0};

        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        supurme();

        // Basic lookup: ps 0x100 -> idx 0x040, counter 10 -> taken.
        cyc(1'b0, 1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        kontrol("lookup_adres", 32'(bag.tablo_adres), 32'h040);
        kontrol("lookup_read", 32'({bag.tablo_en, bag.tablo_yaz}), 32'b10);
        bekle(1);

        // Update then lookup, with engine read/wait/write timing.
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        kontrol("upd_accepted", 32'(bag.yurut_hazir), 32'd1);
        bekle(1);
        kontrol("eng_read", 32'({bag.tablo_en, bag.tablo_yaz, bag.tablo_adres}),
                32'({2'b10, 10'h040}));
        kontrol("gecmis_after_upd", 32'(bag.gecmis), 32'h001);
        bekle(1);
        kontrol("eng_oku_idle", 32'(bag.tablo_en), 32'd0);
        bekle(1);
        kontrol("eng_write", 32'({bag.tablo_en, bag.tablo_yaz, bag.tablo_adres,
                                  bag.tablo_yaz_veri}), 32'({2'b11, 10'h040, 2'b11}));
        bekle(1);
        kontrol("ram_040_after_upd", 32'(ram[10'h040]), 32'd3);
        cyc(1'b0, 1'b1, 32'h104, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        kontrol("lookup2_adres", 32'(bag.tablo_adres), 32'h040);
        bekle(1);

        // Saturation / decrement vectors at one index.
        hedef = 10'h040;
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b1, ps_for(hedef, ref_g), vek[i].dallan, 1'b0, 1'b0);
            kontrol($sformatf("vek%0d_yurut_hazir", i), 32'(bag.yurut_hazir), 32'd1);
            bekle(4);
            kontrol($sformatf("vek%0d_ram", i), 32'(ram[hedef]), 32'(vek[i].sayac));
            kontrol($sformatf("vek%0d_gecmis", i), 32'(bag.gecmis), 32'(ref_g));
            cyc(1'b0, 1'b1, ps_for(hedef, ref_g), 1'b0, 32'd0, 1'b0, 1'b1, vek[i].tahmin);
            kontrol($sformatf("vek%0d_lookup_adres", i), 32'(bag.tablo_adres), 32'(hedef));
            bekle(1);
        end

        // Backpressure: fetch held high, four updates fill the FIFO.
        adr_a = 10'h200;
        adr_b = 10'h300;
        bp_adr[0] = adr_a; bp_dal[0] = 1'b0;
        bp_adr[1] = adr_b; bp_dal[1] = 1'b1;
        bp_adr[2] = adr_a; bp_dal[2] = 1'b0;
        bp_adr[3] = adr_b; bp_dal[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 32'h0, 1'b1, ps_for(bp_adr[k], ref_g), bp_dal[k], 1'b0, 1'b0);
            kontrol($sformatf("bp%0d_hazir", k), 32'({bag.yurut_hazir, bag.getir_hazir}),
                    32'b11);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
            kontrol($sformatf("bp_full%0d_hazir", k),
                    32'({bag.yurut_hazir, bag.getir_hazir}), 32'b00);
        end
        cyc(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        kontrol("bp_getir_after_pop", 32'(bag.getir_hazir), 32'd1);
        bekle(14);
        kontrol("bp_ram_a", 32'(ram[adr_a]), 32'd0);
        kontrol("bp_ram_b", 32'(ram[adr_b]), 32'd2);
        kontrol("bp_gecmis", 32'(bag.gecmis), 32'(ref_g));

        // Reset during an engine write with three entries queued.
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b0, 32'd0, 1'b1, ps_for(10'h123, ref_g), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        kontrol("rst_during_yaz", 32'({bag.tablo_en, bag.tablo_yaz}), 32'b11);
        supurme();

        cyc(1'b0, 1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        bekle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tahmin_tablosu_denetleyici.md
Name: tahmin_tablosu_denetleyici

Overview:
Controller for the gshare pattern-history table. The table is held in an external single-port 2-bit RAM with 1-cycle registered read.
The block owns the global history register and computes both fetch and execute indices. It clears the table after reset, arbitrates the single RAM port between fetch lookups and execute updates, and buffers updates in a small FIFO.
It sits between the fetch/execute stages and the table RAM.

Parameters:
GECMIS_BIT, 10, history width = table index width (table depth 2**GECMIS_BIT)
FIFO_DERINLIK, 4, update FIFO depth (power of 2, >=2)
BASLANGIC, 2'b10, counter value written by clear sweep (weakly taken)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
getir_gecerli  in  1  fetch lookup request
getir_ps  in  32  fetch PC
getir_hazir  out  1  lookup accepted this cycle when getir_gecerli && getir_hazir
tahmin_gecerli  out  1  prediction valid (1 cycle after accept)
tahmin_dallan  out  1  predicted taken, = table MSB
yurut_gecerli  in  1  resolved branch
yurut_ps  in  32  resolved branch PC
yurut_dallan  in  1  actual outcome
yurut_hazir  out  1  update accepted when yurut_gecerli && yurut_hazir
tablo_en  out  1  RAM access this cycle
tablo_yaz  out  1  1 = write, 0 = read
tablo_adres  out  GECMIS_BIT  RAM address
tablo_yaz_veri  out  2  write data
tablo_oku_veri  in  2  read data, valid cycle after read
temizleme_bitti  out  1  clear sweep complete
gecmis  out  GECMIS_BIT  global history register

Behaviour:
- Index: idx = ps[GECMIS_BIT+1:2] ^ gecmis. Fetch uses gecmis in the accept cycle. Execute uses gecmis in the enqueue cycle.
- Reset (rst=1 at edge): FIFO empty, gecmis=0, sweep counter=0, update engine BOS, state TEMIZLE. All outputs 0 except tablo_en=1, tablo_yaz=1, tablo_yaz_veri=BASLANGIC. rst takes effect mid-sweep or mid-update and restarts the sweep; in-flight lookups and queued updates are dropped.
- TEMIZLE: each cycle write BASLANGIC to address = sweep counter, then counter+1. getir_hazir=0 and yurut_hazir=0. After writing address 2**GECMIS_BIT-1 (2**GECMIS_BIT cycles), go to CALIS and set temizleme_bitti=1 (held until rst).
- CALIS, enqueue: if yurut_gecerli && yurut_hazir, push {idx, yurut_dallan}. Same edge: gecmis <= {gecmis[GECMIS_BIT-2:0], yurut_dallan}. yurut_hazir = CALIS && !full. Push and pop in the same cycle is allowed. No push when full.
- Update engine states: BOS -> OKU -> YAZ -> BOS.
  - OKU: read issued at FIFO-head idx.
  - YAZ: write the saturating counter, then pop the head. Taken: 11 stays 11, else +1. Not taken: 00 stays 00, else -1.
- Port priority each CALIS cycle:
  1. Engine in YAZ: write.
  2. Fetch read if getir_gecerli && getir_hazir.
  3. Engine read (BOS -> OKU) if FIFO non-empty.
  4. Otherwise idle (tablo_en=0).
- getir_hazir = CALIS && engine not in YAZ && !full. A full FIFO stalls fetch so updates cannot starve.
- Engine issues its read only in a cycle where fetch does not take the port. OKU lasts exactly 1 cycle.
- Fetch response: cycle after accept, tahmin_gecerli=1 and tahmin_dallan=tablo_oku_veri[1]. Otherwise tahmin_gecerli=0 and tahmin_dallan=0.
- Hazard: a lookup may read a counter with a queued but unwritten update; the stale value is accepted.
- Updates to the same idx serialize through the engine, so no lost increments.
- Throughput: one update per 3 cycles with no fetch traffic; back-to-back lookups every cycle while !full.

Test Plan:
- Clear sweep: rst 1 cycle, GECMIS_BIT=10 -> exactly 1024 writes of 2'b10 at addresses 0..1023 in order; temizleme_bitti rises on cycle 1024; getir_hazir=0 throughout.
- Basic lookup: after sweep, fetch ps=0x100 -> tablo_adres=0x040 read; next cycle tahmin_gecerli=1 and tahmin_dallan=1.
- Update then lookup: execute ps=0x100 taken (idx 0x040, gecmis becomes 0x001) -> engine reads 10, writes 11 at 0x040. Then fetch ps=0x104 (idx 0x041^0x001=0x040) -> tahmin_dallan=1 and RAM holds 11.
- Saturation/decrement: three taken updates at one idx -> stays 11. Then four not-taken -> 10, 01, 00, 00. Lookup returns tahmin_dallan=0.
- Backpressure: getir_gecerli held 1, push 4 updates -> yurut_hazir=0 and getir_hazir=0 at full. Engine drains, getir_hazir returns after the first pop. No update is lost (check RAM contents).
- Reset mid-activity: rst asserted during an engine YAZ cycle with 3 entries queued -> FIFO empty, gecmis=0, new 1024-cycle sweep, no writes other than the sweep.
